// File: rtl/int_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : int_ctrl_pkg
//  Description : Shared definitions for the jacaranda-8 interrupt controller.
//                Holds the FSM state encoding, the default I/O register
//                addresses, the CAUSE register bit positions and the source
//                id width.
//  Revision    : 1.0  initial release
// ============================================================================
package int_ctrl_pkg;

    // Source id width; it fixes the largest supported NUM_SRC at 4.
    localparam int c_id_w = 2;

    // Default register addresses in the 8-bit data-memory I/O space.
    localparam logic [7:0] c_addr_mask_dflt  = 8'd248;
    localparam logic [7:0] c_addr_pend_dflt  = 8'd247;
    localparam logic [7:0] c_addr_cause_dflt = 8'd246;

    // CAUSE register layout: {busy, tmo_flag, 4'b0, cur_id}.
    localparam int c_cause_busy_bit = 7;
    localparam int c_cause_tmo_bit  = 6;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/int_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : int_ctrl_if
//  Description : Data-memory I/O bus between the cpu side and the interrupt
//                controller register file.
//                  access_addr  bus address (rs_data)
//                  w_data       write data (rd_data)
//                  w_en         write strobe (mem_w_en)
//                  r_data       combinational read data
//                  hit          address decodes to a controller register
//  Revision    : 1.0  initial release
// ============================================================================
interface int_ctrl_if;
    logic [7:0] access_addr;
    logic [7:0] w_data;
    logic       w_en;
    logic [7:0] r_data;
    logic       hit;

    modport master (
        output access_addr,
        output w_data,
        output w_en,
        input  r_data,
        input  hit
    );

    modport slave (
        input  access_addr,
        input  w_data,
        input  w_en,
        output r_data,
        output hit
    );
endinterface
`default_nettype wire

// File: rtl/int_src_edge.sv
`default_nettype none
// ============================================================================
//  Module      : int_src_edge
//  Description : Two-flop synchroniser followed by a rising-edge detector for
//                one interrupt source.
//                  clock    system clock
//                  reset_n  asynchronous reset, active low
//                  i_req    raw (possibly asynchronous) request
//                  o_pulse  one-cycle pulse on a synchronised rising edge
//  Revision    : 1.0  initial release
// ============================================================================
module int_src_edge (
    input  wire logic clock,
    input  wire logic reset_n,
    input  wire logic i_req,
    output logic      o_pulse
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= i_req;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // Combinational pulse so that pend latches on the third edge after the rise.
    assign o_pulse = r_sync2 & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/int_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : int_ctrl
//  Description : Multi-source interrupt controller. Edge-detects NUM_SRC
//                requests into sticky pending bits, masks them, picks the
//                lowest eligible index and dispatches it as a one-cycle
//                int_req pulse, then holds it in service until EOI.
//                Optional feature macro: INT_CTRL_EOI_TIMEOUT_EN adds an EOI
//                timeout of TIMEOUT clocks that drops the in-service source
//                and raises tmo_flag.
//                  clock    system clock
//                  reset_n  asynchronous reset, active low
//                  src_req  raw interrupt requests (rising edge = request)
//                  bus      register bus (int_ctrl_if.slave)
//                  int_req  one-cycle interrupt request to the cpu
//                  busy     an interrupt is in service
//  Revision    : 1.0  initial release
// ============================================================================
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int         NUM_SRC    = 4,
    parameter logic [7:0] ADDR_MASK  = c_addr_mask_dflt,
    parameter logic [7:0] ADDR_PEND  = c_addr_pend_dflt,
    parameter logic [7:0] ADDR_CAUSE = c_addr_cause_dflt
`ifdef INT_CTRL_EOI_TIMEOUT_EN
    ,
    parameter int         TIMEOUT    = 255
`endif
) (
    input  wire logic               clock,
    input  wire logic               reset_n,
    input  wire logic [NUM_SRC-1:0] src_req,
    int_ctrl_if.slave               bus,
    output logic                    int_req,
    output logic                    busy
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_id_w-1:0]   r_cur_id;
    logic [c_id_w-1:0]   w_winner;
    logic [NUM_SRC-1:0]  r_mask;
    logic [NUM_SRC-1:0]  r_pend;
    logic [NUM_SRC-1:0]  w_edge;
    logic [NUM_SRC-1:0]  w_elig;
    logic [NUM_SRC-1:0]  w_clr;
    logic [NUM_SRC-1:0]  w_cur_onehot;
    logic                w_load_id;
    logic                w_svc_done;
    logic                w_tmo_hit;
    logic                w_tmo_expire;
    logic                w_tmo_flag;
    logic                w_sel_mask, w_sel_pend, w_sel_cause;
    logic                w_wr_mask, w_wr_pend, w_wr_cause;
    logic                w_eoi;
    logic                w_unused_wdata;

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            int_src_edge u_edge (
                .clock   (clock),
                .reset_n (reset_n),
                .i_req   (src_req[gi]),
                .o_pulse (w_edge[gi])
            );
        end
    endgenerate

    // ---------------- address decode ----------------
    assign w_sel_mask  = (bus.access_addr == ADDR_MASK);
    assign w_sel_pend  = (bus.access_addr == ADDR_PEND);
    assign w_sel_cause = (bus.access_addr == ADDR_CAUSE);
    assign w_wr_mask   = bus.w_en & w_sel_mask;
    assign w_wr_pend   = bus.w_en & w_sel_pend;
    assign w_wr_cause  = bus.w_en & w_sel_cause;

    // Only an EOI naming the in-service source counts, and only in SERVICE.
    assign w_eoi = w_wr_cause && (r_state == ST_SERVICE) &&
                   (bus.w_data[c_id_w-1:0] == r_cur_id);

    // Upper write-data bits have no destination.
    assign w_unused_wdata = &{1'b0, bus.w_data};

    // ---------------- priority encoder ----------------
    assign w_elig = r_pend & r_mask;

    always_comb begin
        w_winner = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_winner = c_id_w'(i);
            end
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load_id   = 1'b0;
        w_svc_done  = 1'b0;
        w_tmo_hit   = 1'b0;
        int_req     = 1'b0;
        busy        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|w_elig) begin
                    w_load_id   = 1'b1;
                    w_state_nxt = ST_ASSERT;
                end
            end
            ST_ASSERT: begin
                int_req     = 1'b1;
                w_state_nxt = ST_SERVICE;
            end
            ST_SERVICE: begin
                busy = 1'b1;
                if (w_eoi) begin
                    w_svc_done  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_tmo_expire) begin
                    w_tmo_hit   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cur_id <= '0;
        end else if (w_load_id) begin
            r_cur_id <= w_winner;
        end
    end

    // ---------------- register file ----------------
    assign w_cur_onehot = NUM_SRC'(1) << r_cur_id;
    assign w_clr = (w_wr_pend ? bus.w_data[NUM_SRC-1:0] : '0) |
                   ((w_svc_done | w_tmo_hit) ? w_cur_onehot : '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_mask <= '0;
            r_pend <= '0;
        end else begin
            if (w_wr_mask) begin
                r_mask <= bus.w_data[NUM_SRC-1:0];
            end
            // A fresh edge beats any clear of the same bit in the same cycle.
            r_pend <= (r_pend & ~w_clr) | w_edge;
        end
    end

`ifdef INT_CTRL_EOI_TIMEOUT_EN
    logic [7:0] r_tmo_cnt;
    logic       r_tmo_flag;

    // Fires on the edge where the counter would reach TIMEOUT, giving
    // exactly TIMEOUT clocks in SERVICE.
    assign w_tmo_expire = ((r_tmo_cnt + 8'd1) == 8'(TIMEOUT));
    assign w_tmo_flag   = r_tmo_flag;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_tmo_cnt  <= 8'd0;
            r_tmo_flag <= 1'b0;
        end else begin
            if (r_state == ST_ASSERT) begin
                r_tmo_cnt <= 8'd0;
            end else if (r_state == ST_SERVICE) begin
                r_tmo_cnt <= r_tmo_cnt + 8'd1;
            end
            if (w_tmo_hit) begin
                r_tmo_flag <= 1'b1;
            end else if (w_wr_cause) begin
                r_tmo_flag <= 1'b0;
            end
        end
    end
`else
    assign w_tmo_expire = 1'b0;
    assign w_tmo_flag   = 1'b0;
`endif

    // ---------------- read mux ----------------
    always_comb begin
        bus.r_data = 8'h00;
        bus.hit    = 1'b0;
        if (w_sel_mask) begin
            bus.hit    = 1'b1;
            bus.r_data = 8'(r_mask);
        end else if (w_sel_pend) begin
            bus.hit    = 1'b1;
            bus.r_data = 8'(r_pend);
        end else if (w_sel_cause) begin
            bus.hit                       = 1'b1;
            bus.r_data[c_cause_busy_bit]  = busy;
            bus.r_data[c_cause_tmo_bit]   = w_tmo_flag;
            bus.r_data[c_id_w-1:0]        = r_cur_id;
        end
    end

endmodule
`default_nettype wire
